// File: rtl/prim_bus_arbiter.sv
// Two-master, single-slave arbiter for the Prim CPU memory bus: round-robin grant,
// optional master-1 lock, and a per-transaction ack timeout.
module prim_bus_arbiter #(
    parameter int unsigned      TMO_W      = 8,
    parameter logic [TMO_W-1:0] TMO_CYCLES = 8'd200
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [15:0] i_m0_addr,
    input  logic [15:0] i_m0_dat,
    input  logic [1:0]  i_m0_bs,
    input  logic        i_m0_we,
    output logic        o_m0_ack,
    input  logic [15:0] i_m1_addr,
    input  logic [15:0] i_m1_dat,
    input  logic [1:0]  i_m1_bs,
    input  logic        i_m1_we,
    output logic        o_m1_ack,
    input  logic        i_m1_lock,
    output logic [15:0] o_m_dat,
    output logic [15:0] o_s_addr,
    output logic [15:0] o_s_dat,
    output logic [1:0]  o_s_bs,
    output logic        o_s_we,
    input  logic [15:0] i_s_dat,
    input  logic        i_s_ack,
    output logic [1:0]  o_grant,
    output logic        o_tmo,
    output logic        o_tmo_sticky
);

    typedef enum logic [1:0] {StIdle, StGrant0, StGrant1} state_e;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_CYCLES - TMO_W'(1);

    state_e           state_q, state_d;
    logic             last_q, last_d;
    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic             sticky_q, sticky_d;

    logic req0, req1;
    logic cur, cur_req, tmo_hit, done;

    assign req0 = |i_m0_bs;
    assign req1 = |i_m1_bs;

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        cur      = 1'b0;
        cur_req  = 1'b0;
        tmo_hit  = 1'b0;
        done     = 1'b0;
        o_grant  = 2'b00;
        o_s_addr = 16'h0000;
        o_s_dat  = 16'h0000;
        o_s_bs   = 2'b00;
        o_s_we   = 1'b0;
        o_m0_ack = 1'b0;
        o_m1_ack = 1'b0;
        o_m_dat  = i_s_dat;
        o_tmo    = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                // On a tie the master that was not served last wins.
                if (req0 && (!req1 || last_q)) begin
                    state_d = StGrant0;
                end else if (req1) begin
                    state_d = StGrant1;
                end
            end
            StGrant0, StGrant1: begin
                cur      = (state_q == StGrant1);
                cur_req  = cur ? req1 : req0;
                o_grant  = cur ? 2'b10 : 2'b01;
                o_s_addr = cur ? i_m1_addr : i_m0_addr;
                o_s_dat  = cur ? i_m1_dat : i_m0_dat;
                o_s_bs   = cur ? i_m1_bs : i_m0_bs;
                o_s_we   = cur ? i_m1_we : i_m0_we;
                if (!cur_req) begin
                    // Master withdrew its request: abort without ack, keep r_last.
                    state_d = StIdle;
                end else begin
                    tmo_hit  = !i_s_ack && (cnt_q == TMO_LAST);
                    done     = i_s_ack || tmo_hit;
                    o_tmo    = tmo_hit;
                    o_m0_ack = done && !cur;
                    o_m1_ack = done && cur;
                    if (tmo_hit) begin
                        o_m_dat = 16'hFFFF;
                    end
                    if (done) begin
                        last_d   = cur;
                        sticky_d = sticky_q | tmo_hit;
                        cnt_d    = '0;
                        state_d  = (cur && i_m1_lock) ? StGrant1 : StIdle;
                    end else if (cnt_q != '1) begin
                        cnt_d = cnt_q + TMO_W'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= StIdle;
            last_q   <= 1'b1;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
        end
    end

    assign o_tmo_sticky = sticky_q;

endmodule

// File: tb/tb_prim_bus_arbiter.sv
// Bench for prim_bus_arbiter: directed scenarios followed by random traffic, all
// checked every cycle against a transaction-level reference model.
module tb_prim_bus_arbiter;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] m0_addr = '0, m0_dat = '0, m1_addr = '0, m1_dat = '0;
    logic [1:0]  m0_bs = '0, m1_bs = '0;
    logic        m0_we = 1'b0, m1_we = 1'b0, m1_lock = 1'b0;
    logic        m0_ack, m1_ack;
    logic [15:0] m_dat, s_addr, s_dat_o;
    logic [1:0]  s_bs, grant;
    logic        s_we, tmo, tmo_sticky;
    logic [15:0] s_dat_i = '0;
    logic        s_ack = 1'b0;

    int checks = 0;
    int failures = 0;

    // Reference model: who owns the bus, who was served last, cycles waited so far.
    int owner;
    int last;
    int waited;
    bit sticky;

    prim_bus_arbiter #(.TMO_W(8), .TMO_CYCLES(8'd4)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_m0_addr(m0_addr), .i_m0_dat(m0_dat), .i_m0_bs(m0_bs), .i_m0_we(m0_we),
        .o_m0_ack(m0_ack),
        .i_m1_addr(m1_addr), .i_m1_dat(m1_dat), .i_m1_bs(m1_bs), .i_m1_we(m1_we),
        .o_m1_ack(m1_ack), .i_m1_lock(m1_lock),
        .o_m_dat(m_dat), .o_s_addr(s_addr), .o_s_dat(s_dat_o), .o_s_bs(s_bs),
        .o_s_we(s_we), .i_s_dat(s_dat_i), .i_s_ack(s_ack),
        .o_grant(grant), .o_tmo(tmo), .o_tmo_sticky(tmo_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check one cycle against the model, then advance model and clock.
    task automatic step();
        logic [1:0]  e_grant = 2'b00, bs_n = 2'b00, e_bs = 2'b00;
        logic [15:0] e_addr = '0, e_sdat = '0, e_mdat;
        logic        e_we = 1'b0, e_ack0 = 1'b0, e_ack1 = 1'b0, e_tmo = 1'b0;
        bit          abort = 1'b0, done = 1'b0;
        #3;
        e_mdat = s_dat_i;
        if (owner >= 0) begin
            e_grant = (owner == 1) ? 2'b10 : 2'b01;
            e_addr  = (owner == 1) ? m1_addr : m0_addr;
            e_sdat  = (owner == 1) ? m1_dat : m0_dat;
            bs_n    = (owner == 1) ? m1_bs : m0_bs;
            e_we    = (owner == 1) ? m1_we : m0_we;
            e_bs    = bs_n;
            abort   = (bs_n == 2'b00);
            e_tmo   = !abort && !s_ack && (waited == TMO - 1);
            done    = !abort && (s_ack || e_tmo);
            e_ack0  = done && (owner == 0);
            e_ack1  = done && (owner == 1);
            if (e_tmo) e_mdat = 16'hFFFF;
        end
        chk("grant", {14'd0, grant}, {14'd0, e_grant});
        chk("s_addr", s_addr, e_addr);
        chk("s_dat", s_dat_o, e_sdat);
        chk("s_bs", {14'd0, s_bs}, {14'd0, e_bs});
        chk("s_we", {15'd0, s_we}, {15'd0, e_we});
        chk("m0_ack", {15'd0, m0_ack}, {15'd0, e_ack0});
        chk("m1_ack", {15'd0, m1_ack}, {15'd0, e_ack1});
        chk("m_dat", m_dat, e_mdat);
        chk("tmo", {15'd0, tmo}, {15'd0, e_tmo});
        chk("tmo_sticky", {15'd0, tmo_sticky}, {15'd0, sticky});
        if (rst) begin
            owner = -1; last = 1; waited = 0; sticky = 1'b0;
        end else if (owner < 0) begin
            waited = 0;
            if (m0_bs != 0 && m1_bs != 0) owner = (last == 1) ? 0 : 1;
            else if (m0_bs != 0) owner = 0;
            else if (m1_bs != 0) owner = 1;
        end else if (abort) begin
            owner = -1;
        end else if (done) begin
            last = owner;
            sticky = sticky | e_tmo;
            waited = 0;
            if (!(owner == 1 && m1_lock)) owner = -1;
        end else if (waited < 255) begin
            waited++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_masters();
        m0_bs = 2'b00; m1_bs = 2'b00; m0_we = 1'b0; m1_we = 1'b0; m1_lock = 1'b0;
    endtask

    logic [1:0] prev;
    int         n;
    bit         reached;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        owner = -1; last = 1; waited = 0; sticky = 1'b0;
        rst = 1'b0;
        chk("reset_grant", {14'd0, grant}, 16'd0);
        chk("reset_sticky", {15'd0, tmo_sticky}, 16'd0);

        // m0 read alone, slave acks one cycle after grant.
        m0_addr = 16'h0010; m0_bs = 2'b01; s_ack = 1'b0;
        step();
        chk("t1_grant", {14'd0, grant}, 16'h0001);
        chk("t1_addr", s_addr, 16'h0010);
        step();
        s_ack = 1'b1; s_dat_i = 16'h00AB;
        #1;
        chk("t1_ack", {15'd0, m0_ack}, 16'd1);
        chk("t1_mdat", m_dat, 16'h00AB);
        chk("t1_m1ack", {15'd0, m1_ack}, 16'd0);
        step();
        m0_bs = 2'b00; s_ack = 1'b0;
        step();

        // Both request continuously with a zero-wait slave: grants alternate.
        m0_bs = 2'b11; m1_bs = 2'b11; m1_addr = 16'h2000; s_ack = 1'b1;
        prev = 2'b00;
        for (int i = 0; i < 10; i++) begin
            if (grant != 2'b00) begin
                if (prev != 2'b00) chk("alternate", {14'd0, grant}, {14'd0, ~prev});
                prev = grant;
            end
            step();
        end
        idle_masters(); s_ack = 1'b0;
        step();

        // Silent slave: timeout on the 4th grant cycle.
        m0_bs = 2'b01; m0_addr = 16'h0F00;
        step();
        for (int i = 0; i < TMO - 1; i++) step();
        #1;
        chk("tmo_pulse", {15'd0, tmo}, 16'd1);
        chk("tmo_ack", {15'd0, m0_ack}, 16'd1);
        chk("tmo_mdat", m_dat, 16'hFFFF);
        step();
        m0_bs = 2'b00;
        step();
        chk("tmo_sticky_hold", {15'd0, tmo_sticky}, 16'd1);

        // m1 locked for three back-to-back writes while m0 waits.
        m0_bs = 2'b01; m1_bs = 2'b11; m1_we = 1'b1; m1_lock = 1'b1; s_ack = 1'b1;
        reached = 1'b0;
        for (int i = 0; i < 6 && !reached; i++) begin
            if (grant == 2'b10) reached = 1'b1;
            else step();
        end
        chk("lock_reach", {15'd0, reached}, 16'd1);
        for (int i = 0; i < 3; i++) begin
            chk("lock_ack", {15'd0, m1_ack}, 16'd1);
            if (i == 2) m1_lock = 1'b0;
            step();
        end
        m1_bs = 2'b00;
        step();
        chk("lock_m0_after", {14'd0, grant}, 16'h0001);
        idle_masters(); s_ack = 1'b0;
        step();
        step();

        // m1 aborts in its 2nd grant cycle; m0 pending gets the bus next.
        m1_bs = 2'b01;
        step();
        step();
        m1_bs = 2'b00; m0_bs = 2'b10;
        #1;
        chk("abort_noack", {15'd0, m1_ack}, 16'd0);
        step();
        chk("abort_idle", {14'd0, grant}, 16'd0);
        step();
        chk("abort_m0", {14'd0, grant}, 16'h0001);
        idle_masters();
        step();

        // Reset asserted mid-GRANT1 with a stalled slave.
        m1_bs = 2'b11;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_grant", {14'd0, grant}, 16'd0);
        chk("rst_bs", {14'd0, s_bs}, 16'd0);
        chk("rst_sticky", {15'd0, tmo_sticky}, 16'd0);
        idle_masters();
        step();

        // Random traffic against the model.
        n = 0;
        repeat (2000) begin
            if ($urandom_range(0, 3) == 0) m0_bs = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) m1_bs = 2'($urandom_range(0, 3));
            m0_addr = 16'($urandom); m1_addr = 16'($urandom);
            m0_dat = 16'($urandom); m1_dat = 16'($urandom);
            m0_we = 1'($urandom); m1_we = 1'($urandom);
            m1_lock = ($urandom_range(0, 2) == 0);
            s_ack = ($urandom_range(0, 2) == 0);
            s_dat_i = 16'($urandom);
            rst = ($urandom_range(0, 199) == 0);
            step();
            n++;
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
